// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: accepts a byte over valid/ready, owns the external
// baud generator (reset + rate select) and serialises start/data/parity/stop.
module uart_tx_ctrl #(
  parameter int         DATA_BITS  = 8,
  parameter logic [1:0] RATE_RESET = 2'd0
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  input  logic [1:0]           cfg_baud,
  input  logic                 cfg_parity_en,
  input  logic                 cfg_parity_odd,
  input  logic                 cfg_two_stop,
  output logic                 bg_resetn,
  output logic [1:0]           baud_rate,
  input  logic                 baud_clk,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

  state_t               state;
  logic [DATA_BITS-1:0] data_sh;
  logic                 parity_bit;
  logic                 parity_en_q;
  logic                 two_stop_q;
  logic [CW-1:0]        bit_cnt;
  logic                 baud_clk_q;
  logic                 phase;

  // The generator toggles baud_clk; a full baud period is two toggles.
  logic edge_det, tick, last_tick;
  assign edge_det  = baud_clk ^ baud_clk_q;
  assign tick      = edge_det & phase;
  assign last_tick = tick && ((state == STOP1 && !two_stop_q) || state == STOP2);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      data_sh     <= '0;
      parity_bit  <= 1'b0;
      parity_en_q <= 1'b0;
      two_stop_q  <= 1'b0;
      bit_cnt     <= '0;
      baud_clk_q  <= 1'b0;
      phase       <= 1'b0;
      tx          <= 1'b1;
      bg_resetn   <= 1'b0;
      baud_rate   <= RATE_RESET;
      tx_ready    <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      baud_clk_q <= baud_clk;
      done       <= 1'b0;
      if (state == IDLE) begin
        phase <= 1'b0;
        if (tx_valid && tx_ready) begin
          data_sh     <= tx_data;
          parity_bit  <= (^tx_data) ^ cfg_parity_odd;
          parity_en_q <= cfg_parity_en;
          two_stop_q  <= cfg_two_stop;
          bit_cnt     <= '0;
          baud_rate   <= cfg_baud;
          state       <= START;
          tx          <= 1'b0;
          bg_resetn   <= 1'b1;
          busy        <= 1'b1;
          tx_ready    <= 1'b0;
        end
      end else begin
        if (edge_det) phase <= ~phase;
        if (last_tick) begin
          state     <= IDLE;
          tx        <= 1'b1;
          bg_resetn <= 1'b0;
          baud_rate <= RATE_RESET;
          busy      <= 1'b0;
          tx_ready  <= 1'b1;
          done      <= 1'b1;
        end else if (tick) begin
          case (state)
            START: begin
              state <= DATA;
              tx    <= data_sh[0];
            end
            DATA: begin
              // data_sh[0] is the bit currently on the line
              if (bit_cnt == LAST_BIT) begin
                state <= parity_en_q ? PARITY : STOP1;
                tx    <= parity_en_q ? parity_bit : 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                data_sh <= data_sh >> 1;
                tx      <= data_sh[1];
              end
            end
            PARITY: begin
              state <= STOP1;
              tx    <= 1'b1;
            end
            STOP1: begin
              state <= STOP2;
              tx    <= 1'b1;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule
